// File: rtl/wireframe_ctrl_if.sv
// Shared coordinate type and the controller's request/strobe bundle.
// The rasterizer/datapath side takes the master modport, the controller the slave modport.
package wireframe_pkg;
    localparam int COORD_W = 12;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point2d_t;
endpackage

interface wireframe_if #(
    parameter int OOB_W = 16
);
    logic                     clear_start;
    logic                     frame_end;
    logic                     pix_valid;
    wireframe_pkg::point2d_t  pix_point;
    logic                     pix_ready;
    logic                     plot;
    wireframe_pkg::point2d_t  plot_point;
    logic                     clear;
    wireframe_pkg::point2d_t  clear_point;
    logic                     busy;
    logic                     clear_done;
    logic                     frame_done;
    logic [OOB_W-1:0]         oob_count;

    modport master (
        output clear_start, frame_end, pix_valid, pix_point,
        input  pix_ready, plot, plot_point, clear, clear_point,
        input  busy, clear_done, frame_done, oob_count
    );

    modport slave (
        input  clear_start, frame_end, pix_valid, pix_point,
        output pix_ready, plot, plot_point, clear, clear_point,
        output busy, clear_done, frame_done, oob_count
    );
endinterface

// File: rtl/wireframe_ctrl.sv
// Frame buffer write-port sequencer: full-frame clear sweep, then pixel admission
// until frame end, with out-of-range pixels dropped and counted.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif

module wireframe_ctrl
    import wireframe_pkg::*;
#(
    parameter int WIDTH  = `WIDTH,
    parameter int HEIGHT = `HEIGHT,
    parameter int OOB_W  = 16
) (
    input  logic         clk,
    input  logic         n_rst,
    wireframe_if.slave   bus
);

    localparam int CX_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int CY_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CX_W-1:0]    CX_LAST = CX_W'(WIDTH - 1);
    localparam logic [CY_W-1:0]    CY_LAST = CY_W'(HEIGHT - 1);
    localparam logic [COORD_W-1:0] X_LIM   = COORD_W'(WIDTH);
    localparam logic [COORD_W-1:0] Y_LIM   = COORD_W'(HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DRAW
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CX_W-1:0]    r_cx;
    logic [CY_W-1:0]    r_cy;
    logic               r_plot;
    point2d_t           r_plot_point;
    logic               r_clear_done;
    logic               r_frame_done;
    logic [OOB_W-1:0]   r_oob;

    logic               w_sweep_last;
    logic               w_in_range;
    logic               w_accept;
    logic               w_restart;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_restart    = 1'b0;
        w_sweep_last = (r_cx == CX_LAST) && (r_cy == CY_LAST);
        w_in_range   = (bus.pix_point.x < X_LIM) && (bus.pix_point.y < Y_LIM);
        case (r_state)
            S_IDLE: begin
                if (bus.clear_start) begin
                    w_state_next = S_CLEAR;
                    w_restart    = 1'b1;
                end
            end
            S_CLEAR: begin
                if (w_sweep_last) begin
                    w_state_next = S_DRAW;
                end
            end
            S_DRAW: begin
                // clear_start wins over frame_end and blocks the handshake
                if (bus.clear_start) begin
                    w_state_next = S_CLEAR;
                    w_restart    = 1'b1;
                end else begin
                    w_accept = bus.pix_valid;
                    if (bus.frame_end) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_clear_done <= 1'b0;
            r_frame_done <= 1'b0;
            r_plot       <= 1'b0;
            r_plot_point <= '0;
        end else begin
            r_state      <= w_state_next;
            r_clear_done <= (r_state == S_CLEAR) && w_sweep_last;
            r_frame_done <= (r_state == S_DRAW) && bus.frame_end && !bus.clear_start;
            r_plot       <= w_accept && w_in_range;
            if (w_accept && w_in_range) begin
                r_plot_point <= bus.pix_point;
            end
        end
    end

    // Sweep counters double as clear_point, so they hold the last point after the sweep.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (w_restart) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if ((r_state == S_CLEAR) && !w_sweep_last) begin
            if (r_cx == CX_LAST) begin
                r_cx <= '0;
                r_cy <= r_cy + 1'b1;
            end else begin
                r_cx <= r_cx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_oob <= '0;
        end else if (w_restart) begin
            r_oob <= '0;
        end else if (w_accept && !w_in_range && !(&r_oob)) begin
            r_oob <= r_oob + 1'b1;
        end
    end

    assign bus.pix_ready     = (r_state == S_DRAW) && !bus.clear_start;
    assign bus.plot          = r_plot;
    assign bus.plot_point    = r_plot_point;
    assign bus.clear         = (r_state == S_CLEAR);
    assign bus.clear_point.x = COORD_W'(r_cx);
    assign bus.clear_point.y = COORD_W'(r_cy);
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.clear_done    = r_clear_done;
    assign bus.frame_done    = r_frame_done;
    assign bus.oob_count     = r_oob;

endmodule

// File: doc/wireframe_ctrl.md
# wireframe_ctrl

Sequencer and arbiter for the wireframe frame buffer write port. It owns the `plot`/`clear` controls of the wireframe plot datapath. On request it sweeps a full-frame clear, then admits rasterizer pixels through a valid/ready handshake until the frame ends. Clearing and plotting never overlap, and out-of-range pixels are filtered and counted.

## Interface
Parameters:
- `WIDTH`, default `` `WIDTH ``: frame width in pixels.
- `HEIGHT`, default `` `HEIGHT ``: frame height in pixels.
- `OOB_W`, default 16: width of the out-of-bounds drop counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `clear_start`  in  1  single-cycle request to clear the buffer and open a new frame.
- `frame_end`  in  1  rasterizer marks that the current frame is complete.
- `pix_valid`  in  1  rasterizer pixel offered.
- `pix_point`  in  Point2D  pixel coordinate; unsigned x and y fields.
- `pix_ready`  out  1  pixel accepted when `pix_valid && pix_ready`.
- `plot`  out  1  plot strobe to the datapath.
- `plot_point`  out  Point2D  plot coordinate.
- `clear`  out  1  clear strobe to the datapath.
- `clear_point`  out  Point2D  clear coordinate.
- `busy`  out  1  high whenever the controller is not in IDLE.
- `clear_done`  out  1  one-cycle pulse when the sweep completes.
- `frame_done`  out  1  one-cycle pulse when the frame closes.
- `oob_count`  out  OOB_W  number of dropped out-of-range pixels; saturates.

## Operation
- FSM has three states: IDLE, CLEAR, DRAW.
- Reset state: IDLE. All outputs are 0, including both points, the sweep counters and `oob_count`.
- **IDLE**
  - `pix_ready`=0.
  - `clear_start` moves the FSM to CLEAR, zeroes the sweep counters and zeroes `oob_count`.
  - `frame_end` and `pix_valid` are ignored.
- **CLEAR**
  - Every cycle the block issues `clear`=1 with `clear_point`=(cx,cy).
  - Sweep order is x-major: cx counts 0..WIDTH-1, then wraps to 0 and cy increments.
  - After (WIDTH-1, HEIGHT-1) is issued, the FSM moves to DRAW.
  - A full sweep is exactly WIDTH*HEIGHT `clear` cycles.
  - `clear_start` and `frame_end` are ignored during CLEAR; the sweep is not restarted.
  - `pix_ready`=0.
- **DRAW**
  - `pix_ready` = !`clear_start` (combinational). All other outputs are registered.
  - On an accepted pixel with x<WIDTH and y<HEIGHT, the next cycle shows `plot`=1 and `plot_point`=`pix_point`.
  - On an accepted pixel with x>=WIDTH or y>=HEIGHT, the pixel is consumed and `plot` stays 0. `oob_count` increments and saturates at all-ones.
  - `frame_end` moves the FSM to IDLE.
    - If a pixel is accepted in the same cycle, it is still plotted.
    - `frame_done` pulses on the next cycle, coincident with that final `plot`.
  - `clear_start` aborts the frame: FSM goes to CLEAR and the sweep restarts from (0,0). No pixel is accepted that cycle and `frame_done` is not pulsed. `clear_start` has priority over a simultaneous `frame_end`.
- `plot` and `clear` are never high in the same cycle.
- `plot_point` and `clear_point` hold their last values while their strobes are low.
- `busy` = (state != IDLE), registered with the state.
- Reset mid-sweep or mid-frame returns immediately to the reset state. No further strobes are issued.

## Timing
- `clear_start` sampled at edge E0 ⇒ first `clear`=1 at (0,0) in the cycle after E0.
  - The last `clear` is in cycle WIDTH*HEIGHT after E0.
  - `clear_done`=1 and `pix_ready`=1 in cycle WIDTH*HEIGHT+1.
- Pixel handshake at edge E ⇒ `plot` strobe visible in the cycle after E. Latency is 1. Sustained throughput is 1 pixel per cycle.
- The datapath writes on the edge that ends each strobe cycle. The controller never stalls it.
- Counter widths:
  - cx holds WIDTH-1 and cy holds HEIGHT-1 without overflow.
  - Comparison is against constants, done at full `pix_point` field width.

## Test plan
Bench uses WIDTH=4, HEIGHT=3.
- Reset, then pulse `clear_start` ⇒ 12 consecutive `clear` cycles: (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2). Then `clear_done` pulses for 1 cycle, `pix_ready`=1, `busy`=1.
- In DRAW, stream (1,1),(3,2),(2,0) with `pix_valid` held high ⇒ `plot`=1 for 3 back-to-back cycles with those points, each 1 cycle after its acceptance.
- Offer (4,0) and (0,3), then (2,2) ⇒ only (2,2) is plotted. `oob_count`=2.
- Assert `frame_end` with an accepted (0,0) ⇒ next cycle `plot` at (0,0) and `frame_done`=1. Following cycle `busy`=0 and `pix_ready`=0.
- `clear_start` together with `pix_valid` and `frame_end` in DRAW ⇒ pixel not accepted and no `frame_done`. A fresh 12-cycle sweep starts at (0,0) and `oob_count` returns to 0.
- Drop `n_rst` at clear cycle 5 ⇒ `clear`, `busy` and the points go to 0 immediately. After release the FSM is in IDLE and `pix_valid` is ignored.
